inst_queue: RTL and testbench

Instruction queue between the instruction-fetch stage and decode. Buffers fetched instruction records (taken flag, next PC, current PC, instruction word) in a DEPTH-entry FIFO, gives fetch back-pressure through `inst_q_wok`, presents the oldest record to decode with a valid/ready handshake, and empties in one cycle on a branch-prediction flush.

---
 rtl/inst_queue_if.sv | 31 +++
 rtl/inst_queue.sv | 76 +++++++
 tb/tb_inst_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode-side bundle of the instruction queue: write port, flush, and the
// decode head with valid/ready handshake plus occupancy/overflow status.
interface inst_queue_if #(
   parameter int INST_Q_WIDTH = 97,
   parameter int PTR_WIDTH    = 2
);
   logic                    inst_q_wen;
   logic [INST_Q_WIDTH-1:0] inst_q_wdata;
   logic                    inst_q_wok;
   logic                    bpu_flush;
   logic                    dec_valid;
   logic                    dec_ready;
   logic [31:0]             dec_inst;
   logic [31:0]             dec_cur_pc;
   logic [31:0]             dec_nxt_pc;
   logic                    dec_taken;
   logic [PTR_WIDTH:0]      q_count;
   logic                    q_ovf;

   modport master (
      output inst_q_wen, inst_q_wdata, bpu_flush, dec_ready,
      input  inst_q_wok, dec_valid, dec_inst, dec_cur_pc, dec_nxt_pc, dec_taken,
             q_count, q_ovf
   );

   modport slave (
      input  inst_q_wen, inst_q_wdata, bpu_flush, dec_ready,
      output inst_q_wok, dec_valid, dec_inst, dec_cur_pc, dec_nxt_pc, dec_taken,
             q_count, q_ovf
   );
endinterface

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with registered back-pressure, valid/ready
// head presentation and single-cycle flush on branch misprediction.
module inst_queue #(
   parameter int INST_Q_WIDTH = 97,
   parameter int DEPTH        = 4,
   parameter int PTR_WIDTH    = 2
) (
   input  logic         CLK,
   input  logic         RSTN,
   inst_queue_if.slave  bus
);
   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

   logic [INST_Q_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [PTR_WIDTH-1:0]    rd_ptr;
   logic [PTR_WIDTH:0]      count;
   logic                    ovf;
   logic                    wok;
   logic                    valid;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    wr_drop;
   logic [INST_Q_WIDTH-1:0] head;

   // wok/valid come from registered count only, so fetch sees no combinational path
   assign wok     = (count != FULL_CNT);
   assign valid   = (count != '0);
   assign wr_acc  = bus.inst_q_wen & wok & ~bus.bpu_flush;
   assign rd_acc  = valid & bus.dec_ready & ~bus.bpu_flush;
   assign wr_drop = bus.inst_q_wen & ~wok & ~bus.bpu_flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_acc) begin
         mem[wr_ptr] <= bus.inst_q_wdata;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.bpu_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky until reset; a flush deliberately leaves it set
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)        ovf <= 1'b0;
      else if (wr_drop) ovf <= 1'b1;
   end

   assign bus.inst_q_wok = wok;
   assign bus.dec_valid  = valid;
   assign bus.dec_inst   = head[31:0];
   assign bus.dec_cur_pc = head[63:32];
   assign bus.dec_nxt_pc = head[95:64];
   assign bus.dec_taken  = head[96];
   assign bus.q_count    = count;
   assign bus.q_ovf      = ovf;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table for fill/overflow/drain, then
// hand sequences for streaming wrap, flush, full read+write and async reset.
module tb_inst_queue;
   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   inst_queue_if #(.INST_Q_WIDTH(97), .PTR_WIDTH(2)) bus ();

   inst_queue #(.INST_Q_WIDTH(97), .DEPTH(4), .PTR_WIDTH(2)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   typedef struct {
      logic        wen;
      logic [31:0] inst;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_inst;
      logic [2:0]  exp_cnt;
      logic        exp_wok;
      logic        exp_ovf;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [96:0] rec(input logic [31:0] inst, input logic [31:0] cur);
      logic [31:0] nxt;
      nxt = inst[0] ? cur + 32'h40 : cur + 32'h4;
      return {inst[0], nxt, cur, inst};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_head(input string name, input logic [31:0] inst, input logic [31:0] cur);
      logic [96:0] r;
      r = rec(inst, cur);
      chk({name, ".valid"}, 64'(bus.dec_valid), 64'd1);
      chk({name, ".inst"},  64'(bus.dec_inst),   64'(r[31:0]));
      chk({name, ".cur"},   64'(bus.dec_cur_pc), 64'(r[63:32]));
      chk({name, ".nxt"},   64'(bus.dec_nxt_pc), 64'(r[95:64]));
      chk({name, ".taken"}, 64'(bus.dec_taken),  64'(r[96]));
   endtask

   task automatic chk_stat(input string name, input logic v, input logic [2:0] c,
                           input logic w, input logic o);
      chk({name, ".valid"}, 64'(bus.dec_valid),  64'(v));
      chk({name, ".count"}, 64'(bus.q_count),    64'(c));
      chk({name, ".wok"},   64'(bus.inst_q_wok), 64'(w));
      chk({name, ".ovf"},   64'(bus.q_ovf),      64'(o));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic wen, input logic [31:0] inst, input logic [31:0] cur,
                        input logic ready, input logic flush);
      bus.inst_q_wen   = wen;
      bus.inst_q_wdata = rec(inst, cur);
      bus.dec_ready    = ready;
      bus.bpu_flush    = flush;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      RSTN = 1'b0;
      #3;
      RSTN = 1'b1;
      step();
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      chk_stat("rst", 1'b0, 3'd0, 1'b1, 1'b0);
      chk("rst.inst", 64'(bus.dec_inst), 64'd0);
      chk("rst.cur",  64'(bus.dec_cur_pc), 64'd0);
      RSTN = 1'b1;
      step();

      // fill, overflow attempt, then drain in order
      tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 3'd1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 3'd2, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 3'd3, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h11, 3'd4, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 32'h55, 1'b0, 1'b1, 32'h11, 3'd4, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 3'd3, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 3'd2, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 3'd1, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 3'd0, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].wen, tbl[i].inst, 32'h1000 + tbl[i].inst, tbl[i].ready, 1'b0);
         step();
         chk_stat($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_cnt,
                  tbl[i].exp_wok, tbl[i].exp_ovf);
         if (tbl[i].exp_valid)
            chk_head($sformatf("vec%0d", i), tbl[i].exp_inst, 32'h1000 + tbl[i].exp_inst);
      end

      // streaming across the pointer wrap
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h500 + 32'(k), 32'h100 + 32'(4*k), 1'b1, 1'b0);
         step();
         chk_stat($sformatf("strm%0d", k), 1'b1, 3'd1, 1'b1, 1'b0);
         chk_head($sformatf("strm%0d", k), 32'h500 + 32'(k), 32'h100 + 32'(4*k));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk_stat("strm_end", 1'b0, 3'd0, 1'b1, 1'b0);

      // flush with concurrent write and read
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'hA1 + 32'(k), 32'h200 + 32'(4*k), 1'b0, 1'b0);
         step();
      end
      chk_stat("pre_flush", 1'b1, 3'd3, 1'b1, 1'b0);
      drive(1'b1, 32'h99, 32'h300, 1'b1, 1'b1);
      step();
      chk_stat("flush", 1'b0, 3'd0, 1'b1, 1'b0);
      drive(1'b1, 32'hAA, 32'h304, 1'b0, 1'b0);
      step();
      chk_stat("post_flush", 1'b1, 3'd1, 1'b1, 1'b0);
      chk_head("post_flush", 32'hAA, 32'h304);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk_stat("post_flush_drain", 1'b0, 3'd0, 1'b1, 1'b0);

      // full queue with simultaneous read and write
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'hB1 + 32'(k), 32'h400 + 32'(4*k), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'hB5, 32'h410, 1'b1, 1'b0);
      step();
      chk_stat("full_rw", 1'b1, 3'd3, 1'b1, 1'b1);
      chk_head("full_rw", 32'hB2, 32'h404);
      drive(1'b1, 32'hB6, 32'h414, 1'b0, 1'b0);
      step();
      chk_stat("full_refill", 1'b1, 3'd4, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk_head("drain_b3", 32'hB3, 32'h408);
      step();
      chk_head("drain_b4", 32'hB4, 32'h40C);
      step();
      chk_head("drain_b6", 32'hB6, 32'h414);
      step();
      chk_stat("drain_end", 1'b0, 3'd0, 1'b1, 1'b1);

      // async reset mid-cycle with two entries queued and ovf set
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'hC1 + 32'(k), 32'h500 + 32'(4*k), 1'b0, 1'b0);
         step();
      end
      chk_stat("pre_rst", 1'b1, 3'd2, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      RSTN = 1'b0;
      #1;
      chk_stat("async_rst", 1'b0, 3'd0, 1'b1, 1'b0);
      chk("async_rst.inst", 64'(bus.dec_inst), 64'd0);
      #2;
      RSTN = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
